// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter and 8N1 frame sequencer for a shared UART tx line
//
// Grants one of NUM_REQ byte sources at a time, latches its byte and
// serialises it LSB first on the baud grid given by bit_tick.
// Optional feature macro: UART_ARB_PARITY_EN (adds an even-parity bit).
//
// Ports:
//   clk       system clock (same clock as the baud generator)
//   reset_n   asynchronous active-low reset
//   bit_tick  one-cycle pulse per bit period
//   req       per-requester transmit request, held with data until granted
//   data      flattened bytes, requester i uses data[8i+7:8i]
//   grant     one-hot pulse: requester's byte has been latched
//   owner     index of the requester whose frame is in progress
//   busy      high from grant until the end of the last stop bit
//   tx        serial line, idle high

module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       bit_tick,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       tx
);

  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [OW-1:0]        last_q, last_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 tx_q, tx_d;
`ifdef UART_ARB_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Round-robin pick: first requester found searching upward from last+1.
  logic          win_vld;
  logic [OW-1:0] win_idx;
  logic [7:0]    win_byte;
  int            cand;

  always_comb begin
    win_vld = 1'b0;
    win_idx = last_q;
    cand    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_q) + i) % NUM_REQ;
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = OW'(cand);
      end
    end
    win_byte = data[int'(win_idx)*8 +: 8];
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    grant_d    = '0;
    busy_d     = busy_q;
    tx_d       = tx_q;
`ifdef UART_ARB_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A tick on the grant edge is deliberately not looked at here.
        if (win_vld) begin
          shift_d = win_byte;
          last_d  = win_idx;
          owner_d = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
          busy_d  = 1'b1;
`ifdef UART_ARB_PARITY_EN
          parity_d = ^win_byte;
`endif
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (bit_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_tick) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_ARB_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = S_STOP;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_ARB_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      last_q     <= OW'(NUM_REQ - 1);
      owner_q    <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
`ifdef UART_ARB_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      tx_q       <= tx_d;
`ifdef UART_ARB_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

  localparam int N = 4;
`ifdef UART_ARB_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           bit_tick = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*8-1:0] data = '0;
  logic [N-1:0]   grant;
  logic [1:0]     owner;
  logic           busy;
  logic           tx;

  int errors = 0;
  int checks = 0;
  int last_m = N - 1;

  int tick_period = 16;
  bit tick_en = 1'b0;
  bit force_tick = 1'b0;
  int div = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .bit_tick(bit_tick), .req(req), .data(data),
    .grant(grant), .owner(owner), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  // Baud tick source, driven on the inactive edge.
  always @(negedge clk) begin
    bit_tick = (tick_en && div == tick_period - 1) || force_tick;
    force_tick = 1'b0;
    if (tick_en) div = (div + 1 >= tick_period) ? 0 : div + 1;
    else div = 0;
  end

  // Frames must never overlap: a grant must follow a cycle with busy low.
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (reset_n && grant != '0) begin
      checks++;
      if (busy_prev !== 1'b0) begin
        errors++;
        $display("FAIL overlap: grant=%b issued while busy was %b", grant, busy_prev);
      end
    end
    busy_prev = busy;
  end

  // Expected line level for each tick period of a frame.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef UART_ARB_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic wait_grant(output int g, input int budget);
    int c;
    g = -1;
    c = 0;
    while (g < 0 && c < budget) begin
      @(negedge clk);
      c++;
      if (grant != '0)
        for (int i = 0; i < N; i++) if (grant[i] && g < 0) g = i;
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge clk);
      if (bit_tick) ok = 1'b1;
    end
    if (ok) @(negedge clk);
  endtask

  task automatic check_frame(input string name, input int exp_owner,
                             input logic [7:0] exp_byte, input bit hold_req);
    int g;
    bit ok;
    logic [10:0] fb;
    wait_grant(g, 600);
    checks++;
    if (g != exp_owner) begin
      errors++;
      $display("FAIL %s grant_index: got %0d want %0d", name, g, exp_owner);
      if (g < 0) return;
    end
    checks++;
    if (grant !== N'(1 << exp_owner)) begin
      errors++;
      $display("FAIL %s grant_onehot: got %b want %b", name, grant, N'(1 << exp_owner));
    end
    checks++;
    if (owner !== 2'(exp_owner) || busy !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s at_grant: owner=%0d busy=%b tx=%b want %0d 1 1", name, owner, busy, tx, exp_owner);
    end
    if (hold_req) data[g*8 +: 8] = 8'($urandom);
    else req[g] = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== '0) begin
      errors++;
      $display("FAIL %s grant_pulse: got %b want 0", name, grant);
    end
    fb = frame_bits(exp_byte);
    for (int k = 0; k < FL; k++) begin
      wait_tick(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s tick_timeout at period %0d", name, k);
        return;
      end
      if (tx !== fb[k]) begin
        errors++;
        $display("FAIL %s tx_period%0d: got %b want %b", name, k, tx, fb[k]);
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_in_stop: got %b want 1", name, busy);
    end
    wait_tick(ok);
    checks++;
    if (!ok || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_fall: ok=%b busy=%b tx=%b want 1 0 1", name, ok, busy, tx);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    last_m = N - 1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || grant !== '0 || busy !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: tx=%b grant=%b busy=%b owner=%0d want 1 0 0 0", tx, grant, busy, owner);
    end
    reset_n = 1'b1;
    tick_en = 1'b1;
  endtask

  task automatic test_single();
    tick_period = 16;
    data[23:16] = 8'hA5;
    req = 4'b0100;
    check_frame("single", 2, 8'hA5, 1'b0);
    last_m = 2;
  endtask

  task automatic test_fairness();
    int exp;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) data[i*8 +: 8] = 8'($urandom);
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp = rr_pick(last_m, req);
      checks++;
      if (exp != order[f]) begin
        errors++;
        $display("FAIL fair_model_order%0d: got %0d want %0d", f, exp, order[f]);
      end
      check_frame("fair", order[f], data[order[f]*8 +: 8], 1'b1);
      last_m = order[f];
    end
    req = '0;
  endtask

  task automatic test_skip();
    tick_period = 8;
    data[15:8] = 8'h3C;
    req = 4'b0010;
    check_frame("skip_pre", 1, 8'h3C, 1'b0);
    data[15:8] = 8'h81;
    data[31:24] = 8'h5E;
    req = 4'b1010;
    check_frame("skip_first", 3, 8'h5E, 1'b0);
    check_frame("skip_second", 1, 8'h81, 1'b0);
    last_m = 1;
  endtask

  task automatic test_tick_on_grant();
    logic [7:0] b;
    b = 8'($urandom);
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    data[7:0] = b;
    req = 4'b0001;
    force_tick = 1'b1;
    tick_period = 12;
    tick_en = 1'b1;
    check_frame("tick_on_grant", 0, b, 1'b0);
    last_m = 0;
  endtask

  task automatic test_mid_reset();
    int g;
    int stray;
    bit ok;
    logic [7:0] b;
    b = 8'($urandom);
    tick_period = 10;
    data[23:16] = b;
    req = 4'b0100;
    wait_grant(g, 200);
    req = '0;
    checks++;
    if (g != 2) begin
      errors++;
      $display("FAIL mid_reset grant: got %0d want 2", g);
    end
    for (int k = 0; k < 5; k++) wait_tick(ok);
    checks++;
    if (tx !== b[3] || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset bit3: tx=%b busy=%b want %b 1", tx, busy, b[3]);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL mid_reset async: tx=%b busy=%b grant=%b want 1 0 0", tx, busy, grant);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    last_m = N - 1;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (grant != '0 || tx !== 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL mid_reset no_regrant: got %0d active cycles want 0", stray);
    end
    data[15:8] = 8'hC3;
    data[23:16] = 8'h19;
    req = 4'b0110;
    check_frame("post_reset_a", 1, 8'hC3, 1'b0);
    check_frame("post_reset_b", 2, 8'h19, 1'b0);
    last_m = 2;
  endtask

  task automatic test_random();
    int exp;
    int d;
    for (int f = 0; f < 12; f++) begin
      tick_period = $urandom_range(3, 20);
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          data[i*8 +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end
      if ($countones(req) > 1 && $urandom_range(0, 3) == 0) begin
        d = $urandom_range(0, N - 1);
        req[d] = 1'b0;
      end
      if (req == '0) begin
        d = $urandom_range(0, N - 1);
        data[d*8 +: 8] = 8'($urandom);
        req[d] = 1'b1;
      end
      exp = rr_pick(last_m, req);
      check_frame("random", exp, data[exp*8 +: 8], 1'b0);
      last_m = exp;
    end
    req = '0;
  endtask

`ifdef UART_ARB_PARITY_EN
  task automatic test_parity();
    logic [10:0] want;
    want = 11'b110_0000_1110;
    checks++;
    if (frame_bits(8'h07) !== want) begin
      errors++;
      $display("FAIL parity_model: got %b want %b", frame_bits(8'h07), want);
    end
    tick_period = 16;
    data[7:0] = 8'h07;
    req = 4'b0001;
    exp_parity_owner();
  endtask

  task automatic exp_parity_owner();
    int exp;
    exp = rr_pick(last_m, req);
    check_frame("parity", exp, 8'h07, 1'b0);
    last_m = exp;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_skip();
    test_tick_on_grant();
    test_mid_reset();
    test_random();
`ifdef UART_ARB_PARITY_EN
    test_parity();
`endif
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and frame sequencer that shares one UART transmit line between `NUM_REQ` byte sources. It sits downstream of the baud-rate generator and consumes its 1x `bit_tick`. It grants one requester at a time, latches that requester's byte, and serialises it as an 8N1 frame (8N1E with parity, see Configuration). A new frame is only scheduled after the current one has fully completed.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.

Ports:
- `clk` input, 1 bit: system clock, the same clock that drives the baud generator.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `bit_tick` input, 1 bit: one-cycle pulse per bit period, from the baud generator.
- `req` input, `NUM_REQ` bits: per-requester transmit request. Hold high with `data` stable until granted.
- `data` input, `NUM_REQ*8` bits: flattened bytes; requester i uses `data[8i+7:8i]`.
- `grant` output, `NUM_REQ` bits: one-hot, one-cycle pulse meaning the requester's byte has been latched.
- `owner` output, `$clog2(NUM_REQ)` bits: index of the requester whose frame is in progress.
- `busy` output, 1 bit: high from the grant until the end of the last stop bit.
- `tx` output, 1 bit: serial line, idle high.

## Operation
- FSM states are IDLE, ALIGN, START, DATA, (PARITY), STOP.
- IDLE:
  - If `req` is non-zero, pick the winner round-robin, searching from `(last+1) mod NUM_REQ` upward.
  - Latch the winner's byte into the shift register, set `last`/`owner` to the winner, pulse `grant[winner]`, set `busy`, and go to ALIGN.
- ALIGN: on the first `bit_tick` sampled while in ALIGN, drive `tx`=0 and go to START. This aligns the start bit to the baud grid.
- START: on `bit_tick`, drive `tx`=bit0 (LSB first), clear the bit counter, and go to DATA.
- DATA:
  - Each `bit_tick` shifts out the next bit.
  - After bit7 has been held for one period: go to PARITY if compiled in, otherwise drive `tx`=1 and go to STOP.
- STOP:
  - Hold `tx`=1 for `STOP_BITS` tick periods.
  - On the final tick, clear `busy` and go to IDLE.
- Once in IDLE, the next arbitration happens on the following cycle at the earliest.
- Arbitration occurs only in IDLE. Changes to `req`/`data` after latching do not affect the frame in flight.
- A requester that drops `req` before it is granted is simply skipped.
- `last` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
- The bit counter is 3 bits and counts 0..7. The stop counter is 1 bit.

## Timing
- Reset values: `tx`=1, `grant`=0, `busy`=0, `owner`=0, state IDLE, shift register 0.
- Asserting `reset_n` low mid-frame forces `tx`=1 asynchronously. The frame is aborted and no grant is re-issued.
- Grant latency: if `req` is high in IDLE at edge t, then `grant` and `busy` are high after edge t. `grant` is low again after edge t+1.
- A `bit_tick` coinciding with the grant edge is ignored. The start bit begins on the next tick.
- Frame length is exactly 1+8+`STOP_BITS` tick periods, plus 1 with parity. Start-bit delay after grant is 1 to one full tick period.
- Each `tx` transition occurs one cycle after the `bit_tick` that triggers it.
- Back-to-back frames:
  - Minimum gap between the end of one frame's stop bit and the next grant is 1 cycle.
  - The line gap before the next start bit is up to one tick period.
- `bit_tick` is never expected in consecutive cycles. If it does arrive that way, each pulse still advances exactly one bit.

## Configuration
- `UART_ARB_PARITY_EN`:
  - Defined: adds a PARITY state between DATA and STOP. It drives the even parity (XOR of the latched byte) for one tick period, and the frame becomes 11 periods with `STOP_BITS`=1.
  - Undefined: no parity state, and the frame is 10 periods.

## Test plan
- Single request: `bit_tick` every 16 clocks, `req`=4'b0100, byte2=8'hA5.
  - Expect `grant`=4'b0100 for one cycle and `owner`=2.
  - Expect `tx` per tick: 0,1,0,1,0,0,1,0,1,1.
  - Expect `busy` to fall at the end of the stop bit.
- Fairness: `req`=4'b1111 held, regranted after each grant.
  - Grant order must be 0,1,2,3,0.
  - No frames overlap, and each frame's bytes must match.
- Skip: `req`=4'b1010 after requester 1 was last served. The next grant must be requester 3, then requester 1.
- Mid-frame reset: pull `reset_n` low during data bit 3. `tx`, `busy` and `grant` must go to 1/0/0 immediately, and a new frame must start cleanly after release.
- Tick on grant edge: make `bit_tick` coincide with the grant cycle. The start bit must begin on the following tick, not the coincident one.
- `UART_ARB_PARITY_EN` with byte 8'h07: `tx` must be 0,1,1,1,0,0,0,0,0,1,1, with parity 1.
